// File: rtl/cpu_ctrl_pkg.sv
// Shared types and instruction encodings for the multi-cycle CPU control sequencer.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5,
    ST_ERROR     = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    ALU_NONE = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_SUB  = 2'b10
  } alu_op_t;

  localparam logic [6:0]  OPC_RTYPE  = 7'b0110011;
  localparam logic [2:0]  F3_ADDSUB  = 3'b000;
  localparam logic [6:0]  F7_ADD     = 7'b0000000;
  localparam logic [6:0]  F7_SUB     = 7'b0100000;
  localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;
  localparam logic [31:0] INSTR_HALT = 32'h0000_0073;

  // Returns the ALU operation for a register-register add/sub, ALU_NONE for anything else.
  function automatic alu_op_t decode_rtype(input logic [31:0] instr);
    alu_op_t op;
    op = ALU_NONE;
    if (instr[6:0] == OPC_RTYPE && instr[14:12] == F3_ADDSUB) begin
      if (instr[31:25] == F7_ADD)      op = ALU_ADD;
      else if (instr[31:25] == F7_SUB) op = ALU_SUB;
    end
    return op;
  endfunction

endpackage

// File: rtl/cpu_control_fsm_sat_counter.sv
// Saturating up-counter: counts inc pulses and holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                    count <= '0;
    else if (inc && (count != '1)) count <= count + 1'b1;
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/decode/execute/writeback sequencer with halt, illegal and
// fetch-timeout detection plus cycle and retired-instruction counters.
module cpu_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [31:0]      instruction,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             reg_we,
  output logic [1:0]       alu_op,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic             timeout_err,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retired_count
);

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_nx;
  logic [7:0] timer_q, timer_nx;
  alu_op_t    alu_q, alu_nx;
  logic       illegal_nx, timeout_nx;
  alu_op_t    dec_op;
  logic       active;

  assign dec_op = decode_rtype(instruction);

  // NOTE: every variable assigned here gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nx   = state_q;
    timer_nx   = timer_q;
    alu_nx     = alu_q;
    illegal_nx = illegal;
    timeout_nx = timeout_err;
    case (state_q)
      ST_IDLE: if (run) state_nx = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready) begin
          state_nx = ST_DECODE;
          timer_nx = '0;
        end else if (timer_q == TIMER_LAST) begin
          state_nx   = ST_ERROR;
          timeout_nx = 1'b1;
        end else begin
          timer_nx = timer_q + 8'd1;
        end
      end
      ST_DECODE: begin
        if (dec_op != ALU_NONE) begin
          alu_nx   = dec_op;
          state_nx = ST_EXECUTE;
        end else if (instruction == INSTR_NOP) begin
          state_nx = run ? ST_FETCH : ST_IDLE;
        end else if (instruction == INSTR_HALT) begin
          state_nx = ST_HALT;
        end else begin
          state_nx   = ST_ERROR;
          illegal_nx = 1'b1;
        end
      end
      ST_EXECUTE:   state_nx = ST_WRITEBACK;
      ST_WRITEBACK: state_nx = run ? ST_FETCH : ST_IDLE;
      default:      state_nx = state_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      alu_q       <= ALU_NONE;
      illegal     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_nx;
      timer_q     <= timer_nx;
      alu_q       <= alu_nx;
      illegal     <= illegal_nx;
      timeout_err <= timeout_nx;
    end
  end

  assign state   = state_q;
  assign mem_req = (state_q == ST_FETCH);
  assign ir_load = (state_q == ST_FETCH) && mem_ready;
  assign halted  = (state_q == ST_HALT);
  assign alu_op  = (state_q == ST_EXECUTE || state_q == ST_WRITEBACK) ? alu_q : ALU_NONE;
  // Writes to x0 are suppressed but the instruction still retires.
  assign reg_we  = (state_q == ST_WRITEBACK) && (instruction[11:7] != 5'd0);
  assign pc_inc  = (state_q == ST_WRITEBACK) ||
                   ((state_q == ST_DECODE) && (instruction == INSTR_NOP));
  assign active  = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                   (state_q == ST_EXECUTE) || (state_q == ST_WRITEBACK);

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (active),
    .count (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_retired_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (pc_inc),
    .count (retired_count)
  );

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: add/sub/x0/nop/halt flows, run drop,
// illegal decode, fetch timeout and asynchronous reset.
module tb_cpu_control_fsm;

  localparam int CNT_W = 32;

  logic             clock = 1'b0;
  logic             reset;
  logic             run;
  logic [31:0]      instruction;
  logic             mem_ready;
  logic             mem_req, ir_load, pc_inc, reg_we;
  logic [1:0]       alu_op;
  logic [2:0]       state;
  logic             halted, illegal, timeout_err;
  logic [CNT_W-1:0] cycle_count, retired_count;

  int checks = 0;
  int errors = 0;

  cpu_control_fsm #(.TIMEOUT(15), .CNT_W(CNT_W)) dut (
    .clock         (clock),
    .reset         (reset),
    .run           (run),
    .instruction   (instruction),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .ir_load       (ir_load),
    .pc_inc        (pc_inc),
    .reg_we        (reg_we),
    .alu_op        (alu_op),
    .state         (state),
    .halted        (halted),
    .illegal       (illegal),
    .timeout_err   (timeout_err),
    .cycle_count   (cycle_count),
    .retired_count (retired_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic async_reset();
    reset = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_cycle", cycle_count, 32'd0);
    check("rst_retired", retired_count, 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    reset       = 1'b0;
    run         = 1'b0;
    mem_ready   = 1'b1;
    instruction = 32'h0;
    #2;
    check("init_state", 32'(state), 32'd0);
    check("init_outs", {mem_req, ir_load, pc_inc, reg_we, alu_op, halted, illegal, timeout_err}, 32'd0);
    check("init_cnt", cycle_count | retired_count, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    check("idle_hold", 32'(state), 32'd0);

    // add x1,x2,x3 then halt
    run = 1'b1;
    instruction = 32'h003100B3;
    tick();
    check("add_fetch", 32'(state), 32'd1);
    check("add_fetch_req", {mem_req, ir_load}, 32'b11);
    tick();
    check("add_decode", 32'(state), 32'd2);
    check("add_decode_alu", 32'(alu_op), 32'd0);
    tick();
    check("add_exec", 32'(state), 32'd3);
    check("add_exec_ctl", {alu_op, reg_we, pc_inc}, {28'd0, 2'b01, 1'b0, 1'b0});
    tick();
    check("add_wb", 32'(state), 32'd4);
    check("add_wb_ctl", {alu_op, reg_we, pc_inc}, {28'd0, 2'b01, 1'b1, 1'b1});
    instruction = 32'h00000073;
    tick();
    check("halt_fetch", 32'(state), 32'd1);
    check("add_retired", retired_count, 32'd1);
    tick();
    check("halt_decode", 32'(state), 32'd2);
    check("halt_no_pcinc", 32'(pc_inc), 32'd0);
    tick();
    check("halt_state", 32'(state), 32'd5);
    check("halted", 32'(halted), 32'd1);
    check("halt_cycle", cycle_count, 32'd6);
    check("halt_retired", retired_count, 32'd1);
    tick();
    check("halt_sticky", 32'(state), 32'd5);
    check("halt_cycle_frz", cycle_count, 32'd6);

    // sub x5,x4,x1 ; add x0,x1,x2 ; add with run dropped in EXECUTE
    tick();
    async_reset();
    instruction = 32'h401202B3;
    tick();
    tick();
    tick();
    check("sub_exec_ctl", {alu_op, reg_we}, {29'd0, 2'b10, 1'b0});
    tick();
    check("sub_wb_ctl", {state, alu_op, reg_we, pc_inc}, {25'd0, 3'd4, 2'b10, 1'b1, 1'b1});
    instruction = 32'h00208033;
    tick();
    check("x0_fetch_ret", retired_count, 32'd1);
    tick();
    tick();
    check("x0_exec_alu", 32'(alu_op), 32'd1);
    tick();
    check("x0_wb_ctl", {state, reg_we, pc_inc}, {27'd0, 3'd4, 1'b0, 1'b1});
    instruction = 32'h003100B3;
    tick();
    check("x0_retired", retired_count, 32'd2);
    tick();
    tick();
    check("drop_exec", 32'(state), 32'd3);
    run = 1'b0;
    tick();
    check("drop_wb_ctl", {state, alu_op, reg_we, pc_inc}, {25'd0, 3'd4, 2'b01, 1'b1, 1'b1});
    tick();
    check("drop_idle", 32'(state), 32'd0);
    check("drop_retired", retired_count, 32'd3);
    check("drop_cycle", cycle_count, 32'd12);
    tick();
    check("drop_idle_cycle", cycle_count, 32'd12);
    check("idle_alu_zero", 32'(alu_op), 32'd0);

    // resume with two nops, run dropped during the second
    instruction = 32'h00000013;
    run = 1'b1;
    tick();
    check("nop_fetch", 32'(state), 32'd1);
    tick();
    check("nop_decode_ctl", {state, pc_inc, reg_we, alu_op}, {25'd0, 3'd2, 1'b1, 1'b0, 2'b00});
    tick();
    check("nop_next_fetch", 32'(state), 32'd1);
    check("nop_retired", retired_count, 32'd4);
    tick();
    run = 1'b0;
    tick();
    check("nop_idle", 32'(state), 32'd0);
    check("nop2_retired", retired_count, 32'd5);
    check("nop_cycle", cycle_count, 32'd16);

    // illegal instruction, then asynchronous reset out of ERROR
    instruction = 32'hFFFFFFFF;
    run = 1'b1;
    tick();
    tick();
    check("ill_decode_pcinc", {state, pc_inc}, {28'd0, 3'd2, 1'b0});
    tick();
    check("ill_state", {state, illegal, pc_inc, timeout_err}, {26'd0, 3'd6, 1'b1, 1'b0, 1'b0});
    tick();
    check("ill_sticky", {state, illegal, pc_inc}, {28'd0, 3'd6, 1'b1, 1'b0});
    check("ill_retired", retired_count, 32'd5);
    async_reset();

    // fetch timeout with memory never ready
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) begin
      check($sformatf("to_fetch_%0d", i), {state, mem_req, ir_load}, {27'd0, 3'd1, 1'b1, 1'b0});
      tick();
    end
    check("to_state", {state, timeout_err, mem_req}, {27'd0, 3'd6, 1'b1, 1'b0});
    check("to_cycle", cycle_count, 32'd15);
    mem_ready = 1'b1;
    tick();
    check("to_frozen", {state, timeout_err, illegal, mem_req, ir_load}, {25'd0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0});
    check("to_cycle_frz", cycle_count, 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench did not finish");
  end

endmodule
